pkt_hdr_mem: RTL and testbench
==============================

# pkt_hdr_mem

Parametrised, multi-channel packet header memory. It replaces the single-reader packet RAM that feeds one switch pipeline. NUM_CH independent read channels (switch pipelines or parser stages) share one single-ported storage array through a round-robin arbiter with a request/grant handshake. A load port writes packets into the array, and a saturating counter records contention cycles.

## Interface
Parameters:
- DATA_WIDTH, default `DATA_WIDTH: word width.
- ADDR_WIDTH, default `ADDR_WIDTH: address width.
- DEPTH, default 256: number of words; must satisfy DEPTH ≤ 2^ADDR_WIDTH.
- NUM_CH, default `NUM_CH (4): read channels; must be ≥ 1.
- CNT_WIDTH, default 16: width of the stall counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  load-port write strobe.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- rd_req  in  NUM_CH  per-channel read request.
- rd_addr  in  NUM_CH*ADDR_WIDTH  per-channel address; channel i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rd_gnt  out  NUM_CH  one-hot grant, combinational in the request cycle.
- rd_valid  out  NUM_CH  one-cycle pulse: data for channel i is present.
- rd_data  out  NUM_CH*DATA_WIDTH  per-channel read data; holds until that channel's next valid.
- rd_err  out  NUM_CH  pulses together with rd_valid when the address is ≥ DEPTH.
- stall_cnt  out  CNT_WIDTH  saturating count of contention cycles.

## Operation
- The array performs one access per cycle. A write has absolute priority over reads.
- **Write:** when wr_en=1 and rst=0, mem[wr_addr] ← wr_data at the clock edge. A write with wr_addr ≥ DEPTH is silently dropped.
- **Read arbitration:** when wr_en=0 and rst=0, the arbiter grants exactly one requesting channel, chosen round-robin from pointer rr_ptr.
  - The search order is rr_ptr, rr_ptr+1, …, wrapping modulo NUM_CH.
  - After a grant to channel g, rr_ptr ← (g+1) mod NUM_CH.
  - If nothing is granted, rr_ptr is unchanged.
- **Handshake:** a channel holds rd_req=1 and a stable rd_addr until it sees rd_gnt. rd_req may be deasserted, or a new address presented, in the cycle after the grant. Withdrawing a request before it is granted is legal and has no side effect.
- **Response:** the cycle after a grant, rd_valid[g]=1 and rd_data[g]=mem[addr]. If addr ≥ DEPTH, rd_data[g]=0 and rd_err[g]=1. Other channels' rd_data are unchanged.
- **stall_cnt:** increments (saturating at all-ones) in every cycle where at least one rd_req bit is high and that channel is not granted. This includes cycles blocked by a write and cycles where two or more channels request.
- Array contents are not reset. Only control state and outputs are reset.

## Timing
- Reset values: rd_gnt=0, rd_valid=0, rd_data=0, rd_err=0, stall_cnt=0, rr_ptr=0.
- While rst=1: rd_gnt=0, writes are ignored, stall_cnt does not count.
- **Read latency:** grant in cycle t, rd_valid/rd_data in cycle t+1. Throughput is one read per cycle in aggregate.
- **Reset mid-operation:** if rst=1 in cycle t+1 after a grant in cycle t, that response is discarded, so rd_valid stays 0.
- **Write/read same cycle:** the read is not granted and retries. A read granted in the cycle after a write to the same address returns the new data.
- **Back-to-back:** a single channel requesting continuously is granted every cycle.
- **NUM_CH=1:** degenerates to a stall-on-write RAM with no fairness logic.

## Structure
- def.v gains `NUM_CH. DATA_WIDTH and ADDR_WIDTH remain there.
- Sub-module rr_arbiter (parameter N) covers the arbitration:
  - inputs: req[N], en, ptr;
  - output: one-hot gnt[N];
  - the rr_ptr register lives in pkt_hdr_mem.
- The memory array is inferred as a single-port synchronous RAM inside pkt_hdr_mem.
- The top-level SoC wrapper instantiates one switch per channel, connected to the matching channel slice.

## Test plan
- **Reset, write, single read:** reset, then write mem[5]=0xA5A5_0001; channel 0 requests addr 5.
  - Required: rd_gnt=0001 in the same cycle.
  - Required: next cycle rd_valid[0]=1, rd_data[0]=0xA5A5_0001, stall_cnt=0.
- **Four channels contend:** with NUM_CH=4, all channels request continuously from rr_ptr=0.
  - Required: grant order 0,1,2,3,0.
  - Required: stall_cnt increases by 1 per cycle.
- **Write priority:** wr_en=1 to addr 7 while channel 2 requests addr 7.
  - Required: no grant in the write cycle.
  - Required: channel 2 is granted the next cycle and receives the new value; stall_cnt=1.
- **Out of range:** with DEPTH=200, channel 1 reads addr 250.
  - Required: rd_valid[1]=1, rd_err[1]=1, rd_data[1]=0.
  - Required: a write to 250 leaves all other contents unchanged.
- **Reset mid-operation:** channel 3 is granted in cycle t and rst=1 in cycle t+1.
  - Required: rd_valid stays 0 and all outputs return to their reset values.
  - Required: the next grant after reset starts its search from channel 0.
- **Saturation:** with CNT_WIDTH=4, hold two requesters for 40 cycles.
  - Required: stall_cnt stops at 15.

Source files
------------

// File: rtl/pkt_hdr_mem_pkg.sv
// Shared defaults and helpers for the multi-channel packet header memory.
package pkt_hdr_mem_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_NUM_CH     = 4;

  // Width of an index over n items; never zero so N=1 still has a legal vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pkt_hdr_mem_if.sv
// Load port plus per-channel read request/grant/response bundle.
interface pkt_hdr_mem_if
  import pkt_hdr_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int CNT_WIDTH  = 16
);
  logic                                 wr_en;
  logic [ADDR_WIDTH-1:0]                wr_addr;
  logic [DATA_WIDTH-1:0]                wr_data;
  logic [NUM_CH-1:0]                    rd_req;
  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]    rd_addr;
  logic [NUM_CH-1:0]                    rd_gnt;
  logic [NUM_CH-1:0]                    rd_valid;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]    rd_data;
  logic [NUM_CH-1:0]                    rd_err;
  logic [CNT_WIDTH-1:0]                 stall_cnt;

  modport master (
    output wr_en, wr_addr, wr_data, rd_req, rd_addr,
    input  rd_gnt, rd_valid, rd_data, rd_err, stall_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_req, rd_addr,
    output rd_gnt, rd_valid, rd_data, rd_err, stall_cnt
  );
endinterface

// File: rtl/pkt_hdr_mem_rr_arbiter.sv
// Round-robin one-hot arbiter; the pointer register is owned by the caller.
module rr_arbiter
  import pkt_hdr_mem_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic                  en,
  input  logic [idx_w(N)-1:0]   ptr,
  output logic [N-1:0]          gnt
);
  // A requester wins when no other requester sits closer to ptr in search order.
  always_comb begin
    gnt = '0;
    for (int c = 0; c < N; c++) begin
      if (en && req[c]) begin
        gnt[c] = 1'b1;
        for (int d = 0; d < N; d++) begin
          if (req[d] && (((d + N - int'(ptr)) % N) < ((c + N - int'(ptr)) % N)))
            gnt[c] = 1'b0;
        end
      end
    end
  end
endmodule

// File: rtl/pkt_hdr_mem.sv
// Single-port header RAM shared by NUM_CH readers; writes pre-empt reads.
module pkt_hdr_mem
  import pkt_hdr_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = 256,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic        clk,
  input  logic        rst,
  pkt_hdr_mem_if.slave bus
);
  localparam int                  PW      = idx_w(NUM_CH);
  localparam int                  IW      = idx_w(DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  logic [NUM_CH-1:0]                 gnt;
  logic [PW-1:0]                     rr_ptr_q, rr_ptr_d;
  logic [ADDR_WIDTH-1:0]             gaddr;
  logic                              wr_ok, rd_ok, stall;
  logic [DATA_WIDTH-1:0]             rdata;
  logic [CNT_WIDTH-1:0]              cnt_q, cnt_d;
  logic [NUM_CH-1:0]                 vld_q, err_q;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0]             mem_q [DEPTH];

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .req (bus.rd_req),
    .en  (!bus.wr_en && !rst),
    .ptr (rr_ptr_q),
    .gnt (gnt)
  );

  always_comb begin
    gaddr    = '0;
    rr_ptr_d = rr_ptr_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt[c]) begin
        gaddr    = bus.rd_addr[c];
        rr_ptr_d = PW'((c + 1) % NUM_CH);
      end
    end
  end

  assign wr_ok = !rst && bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_L);
  assign rd_ok = {1'b0, gaddr} < DEPTH_L;
  // Indices are only used once the range check has passed, so truncation is safe.
  assign rdata = rd_ok ? mem_q[gaddr[IW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[bus.wr_addr[IW-1:0]] <= bus.wr_data;
  end

  assign stall = !rst && |(bus.rd_req & ~gnt);

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_comb begin
    data_d = data_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt[c]) data_d[c] = rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      vld_q    <= '0;
      err_q    <= '0;
      data_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      vld_q    <= gnt;
      err_q    <= gnt & {NUM_CH{!rd_ok}};
      data_q   <= data_d;
    end
  end

  // Reset masks a response already in flight so it never becomes visible.
  assign bus.rd_gnt    = gnt;
  assign bus.rd_valid  = vld_q & {NUM_CH{!rst}};
  assign bus.rd_err    = err_q & {NUM_CH{!rst}};
  assign bus.rd_data   = rst ? '0 : data_q;
  assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_pkt_hdr_mem.sv
// Random + directed bench for pkt_hdr_mem against a cycle-level behavioural model.
module tb_pkt_hdr_mem;
  localparam int DW = 32, AW = 8, DEPTH = 200, NCH = 4, CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pkt_hdr_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NCH), .CNT_WIDTH(CW)) bus ();

  pkt_hdr_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NUM_CH(NCH), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vecs = 0;
  int errs = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  int              m_ptr = 0;
  int              m_cnt = 0;
  logic [DW-1:0]   m_mem [DEPTH];
  bit              m_vld [NCH];
  bit              m_err [NCH];
  logic [DW-1:0]   m_data [NCH];
  int              last_g = -1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_grant();
    if (rst || bus.wr_en) return -1;
    for (int k = 0; k < NCH; k++) begin
      if (bus.rd_req[(m_ptr + k) % NCH]) return (m_ptr + k) % NCH;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    g = exp_grant();
    if (rst) begin
      m_ptr = 0;
      m_cnt = 0;
      for (int c = 0; c < NCH; c++) begin
        m_vld[c] = 0; m_err[c] = 0; m_data[c] = '0;
      end
    end else begin
      if (bus.wr_en && int'(bus.wr_addr) < DEPTH) m_mem[int'(bus.wr_addr)] = bus.wr_data;
      for (int c = 0; c < NCH; c++) begin
        m_vld[c] = 0; m_err[c] = 0;
      end
      for (int c = 0; c < NCH; c++) begin
        if (bus.rd_req[c] && c != g) begin
          if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
          break;
        end
      end
      if (g >= 0) begin
        m_vld[g] = 1;
        if (int'(bus.rd_addr[g]) >= DEPTH) begin
          m_err[g]  = 1;
          m_data[g] = '0;
        end else begin
          m_data[g] = m_mem[int'(bus.rd_addr[g])];
        end
        m_ptr = (g + 1) % NCH;
      end
    end
    last_g = g;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int g;
      logic [NCH-1:0] e_gnt, e_vld, e_err;
      logic [NCH-1:0][DW-1:0] e_data;
      g = exp_grant();
      e_gnt = '0;
      if (g >= 0) e_gnt[g] = 1'b1;
      for (int c = 0; c < NCH; c++) begin
        e_vld[c]  = rst ? 1'b0 : m_vld[c];
        e_err[c]  = rst ? 1'b0 : m_err[c];
        e_data[c] = rst ? '0 : m_data[c];
      end
      chk("model_gnt",   128'(bus.rd_gnt),    128'(e_gnt));
      chk("model_valid", 128'(bus.rd_valid),  128'(e_vld));
      chk("model_err",   128'(bus.rd_err),    128'(e_err));
      chk("model_data",  128'(bus.rd_data),   128'(e_data));
      chk("model_stall", 128'(bus.stall_cnt), 128'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  bit            pend  [NCH];
  logic [AW-1:0] paddr [NCH];

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_req = '0;  bus.rd_addr = '0;
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_gnt",   128'(bus.rd_gnt),    128'(0));
    chk("rst_valid", 128'(bus.rd_valid),  128'(0));
    chk("rst_data",  128'(bus.rd_data),   128'(0));
    chk("rst_stall", 128'(bus.stall_cnt), 128'(0));
    step();
    rst = 1'b0;

    // Fill every word with a known pattern
    for (int i = 0; i < DEPTH; i++) begin
      bus.wr_en = 1'b1; bus.wr_addr = AW'(i); bus.wr_data = 32'hC0DE_0000 | 32'(i);
      step();
    end

    // Write then single read
    bus.wr_addr = 8'd5; bus.wr_data = 32'hA5A5_0001;
    step();
    bus.wr_en = 1'b0; bus.rd_req = 4'b0001; bus.rd_addr[0] = 8'd5;
    @(negedge clk);
    chk("t1_gnt", 128'(bus.rd_gnt), 128'(4'b0001));
    step();
    bus.rd_req = '0;
    @(negedge clk);
    chk("t1_valid", 128'(bus.rd_valid[0]),  128'(1));
    chk("t1_data",  128'(bus.rd_data[0]),   128'(32'hA5A5_0001));
    chk("t1_stall", 128'(bus.stall_cnt),    128'(0));

    // Four channels contend from pointer 0
    rst = 1'b1; step();
    rst = 1'b0; bus.rd_req = 4'b1111;
    bus.rd_addr[0] = 8'd10; bus.rd_addr[1] = 8'd11; bus.rd_addr[2] = 8'd12; bus.rd_addr[3] = 8'd13;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("t2_gnt",   128'(bus.rd_gnt),    128'(1 << (j % 4)));
      chk("t2_stall", 128'(bus.stall_cnt), 128'(j));
      step();
    end
    bus.rd_req = '0;

    // Write pre-empts a read of the same address
    rst = 1'b1; step();
    rst = 1'b0; bus.wr_en = 1'b1; bus.wr_addr = 8'd7; bus.wr_data = 32'h7777_1234;
    bus.rd_req = 4'b0100; bus.rd_addr[2] = 8'd7;
    @(negedge clk);
    chk("t3_gnt_blocked", 128'(bus.rd_gnt), 128'(0));
    step();
    bus.wr_en = 1'b0;
    @(negedge clk);
    chk("t3_gnt", 128'(bus.rd_gnt), 128'(4'b0100));
    step();
    bus.rd_req = '0;
    @(negedge clk);
    chk("t3_valid", 128'(bus.rd_valid),   128'(4'b0100));
    chk("t3_data",  128'(bus.rd_data[2]), 128'(32'h7777_1234));
    chk("t3_stall", 128'(bus.stall_cnt),  128'(1));

    // Out of range reads and a dropped write
    bus.rd_req = 4'b0010; bus.rd_addr[1] = 8'd250;
    step();
    bus.rd_req = '0; bus.wr_en = 1'b1; bus.wr_addr = 8'd250; bus.wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t4_valid", 128'(bus.rd_valid),   128'(4'b0010));
    chk("t4_err",   128'(bus.rd_err),     128'(4'b0010));
    chk("t4_data",  128'(bus.rd_data[1]), 128'(0));
    step();
    bus.wr_en = 1'b0; bus.rd_req = 4'b0010; bus.rd_addr[1] = 8'd122;
    step();
    bus.rd_addr[1] = 8'd199;
    @(negedge clk);
    chk("t4_alias", 128'(bus.rd_data[1]), 128'(32'hC0DE_007A));
    step();
    bus.rd_addr[1] = 8'd200;
    @(negedge clk);
    chk("t4_last",     128'(bus.rd_data[1]), 128'(32'hC0DE_00C7));
    chk("t4_last_err", 128'(bus.rd_err),     128'(0));
    step();
    bus.rd_req = '0;
    @(negedge clk);
    chk("t4_edge_err", 128'(bus.rd_err), 128'(4'b0010));

    // Reset right after a grant
    rst = 1'b1; step();
    rst = 1'b0; bus.rd_req = 4'b1000; bus.rd_addr[3] = 8'd3;
    @(negedge clk);
    chk("t5_gnt", 128'(bus.rd_gnt), 128'(4'b1000));
    step();
    rst = 1'b1; bus.rd_req = '0;
    @(negedge clk);
    chk("t5_valid", 128'(bus.rd_valid), 128'(0));
    chk("t5_data",  128'(bus.rd_data),  128'(0));
    step();
    rst = 1'b0; bus.rd_req = 4'b0001; bus.rd_addr[0] = 8'd5;
    step();
    rst = 1'b1; bus.rd_req = '0;
    step();
    rst = 1'b0; bus.rd_req = 4'b0011; bus.rd_addr[0] = 8'd5; bus.rd_addr[1] = 8'd6;
    @(negedge clk);
    chk("t5_ptr_restart", 128'(bus.rd_gnt), 128'(4'b0001));
    step();
    bus.rd_req = 4'b0010;
    @(negedge clk);
    chk("t5_data0", 128'(bus.rd_data[0]), 128'(32'hA5A5_0001));
    step();
    bus.rd_req = '0;

    // Counter saturation
    rst = 1'b1; step();
    rst = 1'b0; bus.rd_req = 4'b0011;
    repeat (40) step();
    @(negedge clk);
    chk("t6_sat", 128'(bus.stall_cnt), 128'(15));
    bus.rd_req = '0;
    step();

    // Randomised traffic obeying the hold-until-granted handshake
    for (int c = 0; c < NCH; c++) begin pend[c] = 0; paddr[c] = '0; end
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      bus.wr_en   = ($urandom_range(0, 5) == 0);
      bus.wr_addr = AW'($urandom_range(0, 255));
      bus.wr_data = $urandom;
      for (int c = 0; c < NCH; c++) begin
        if (pend[c] && last_g == c) pend[c] = 0;
        else if (pend[c] && $urandom_range(0, 15) == 0) pend[c] = 0;
        if (!pend[c] && $urandom_range(0, 2) == 0) begin
          pend[c]  = 1;
          paddr[c] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(DEPTH, 255))
                                                 : AW'($urandom_range(0, DEPTH - 1));
        end
        bus.rd_req[c]  = pend[c];
        bus.rd_addr[c] = paddr[c];
      end
      step();
    end
    rst = 1'b0; bus.wr_en = 1'b0; bus.rd_req = '0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
